// File: rtl/timebase_gen_pkg.sv
// Shared ratios and width helper for the time-base generator.
// Combinational helpers only; no latency or backpressure.
package timebase_gen_pkg;

  localparam int DEF_CLK_PER_SEC  = 256;
  localparam int DEF_SEC_PER_MIN  = 60;
  localparam int DEF_MIN_PER_HOUR = 60;

  // Counter width for a modulus; a modulus of 1 or 2 still needs one bit.
  function automatic int clog2_min1(input int modulus);
    int w;
    w = $clog2(modulus);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/timebase_gen_if.sv
// Control/strobe bundle between the time base and its consumers; hold exists only with TIMEBASE_HOLD_EN.
// Plain wires, no latency; no backpressure.
interface timebase_gen_if #(
  parameter int SEC_W = 6,
  parameter int MIN_W = 6
);

  logic             reset_count;
  logic             fastwatch;
`ifdef TIMEBASE_HOLD_EN
  logic             hold;
`endif
  logic             one_second;
  logic             one_minute;
  logic             one_hour;
  logic [SEC_W-1:0] sec_count;
  logic [MIN_W-1:0] min_count;

`ifdef TIMEBASE_HOLD_EN
  modport master (
    output reset_count, fastwatch, hold,
    input  one_second, one_minute, one_hour, sec_count, min_count
  );
  modport slave (
    input  reset_count, fastwatch, hold,
    output one_second, one_minute, one_hour, sec_count, min_count
  );
`else
  modport master (
    output reset_count, fastwatch,
    input  one_second, one_minute, one_hour, sec_count, min_count
  );
  modport slave (
    input  reset_count, fastwatch,
    output one_second, one_minute, one_hour, sec_count, min_count
  );
`endif

endinterface

// File: rtl/timebase_gen_mod_counter.sv
// Modulo-MOD counter with sync clear (priority) and enable; wrap flags the terminal enabled count.
// Value updates on the clock edge; wrap is combinational; no backpressure.
module mod_counter
  import timebase_gen_pkg::*;
#(
  parameter int MOD = 2,
  parameter int W   = clog2_min1(MOD)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] value,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (enable) begin
      value <= (value == LAST) ? '0 : value + W'(1);
    end
  end

  assign wrap = enable & (value == LAST);

endmodule

// File: rtl/timebase_gen.sv
// Second/minute/hour strobe generator with running counts; optional hold under TIMEBASE_HOLD_EN.
// Strobes are registered (one cycle after terminal count); free-running, no backpressure.
module timebase_gen
  import timebase_gen_pkg::*;
#(
  parameter int CLK_PER_SEC  = DEF_CLK_PER_SEC,
  parameter int SEC_PER_MIN  = DEF_SEC_PER_MIN,
  parameter int MIN_PER_HOUR = DEF_MIN_PER_HOUR
) (
  input logic           clock,
  input logic           reset,
  timebase_gen_if.slave tb_if
);

  localparam int PRE_W = clog2_min1(CLK_PER_SEC);
  localparam int SEC_W = clog2_min1(SEC_PER_MIN);
  localparam int MIN_W = clog2_min1(MIN_PER_HOUR);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_SEC - 1);

  logic             count_en;
  logic [PRE_W-1:0] pre_value;
  logic             pre_wrap;
  logic [SEC_W-1:0] sec_value;
  logic             sec_wrap;
  logic [MIN_W-1:0] min_value;
  logic             min_wrap;
  logic             one_second_q;
  logic             min_strobe_q;
  logic             hour_strobe_q;

`ifdef TIMEBASE_HOLD_EN
  assign count_en = ~tb_if.hold;
`else
  assign count_en = 1'b1;
`endif

  mod_counter #(.MOD(CLK_PER_SEC), .W(PRE_W)) u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .clear  (tb_if.reset_count),
    .enable (count_en),
    .value  (pre_value),
    .wrap   (pre_wrap)
  );

  mod_counter #(.MOD(SEC_PER_MIN), .W(SEC_W)) u_seconds (
    .clock  (clock),
    .reset  (reset),
    .clear  (tb_if.reset_count),
    .enable (pre_wrap),
    .value  (sec_value),
    .wrap   (sec_wrap)
  );

  mod_counter #(.MOD(MIN_PER_HOUR), .W(MIN_W)) u_minutes (
    .clock  (clock),
    .reset  (reset),
    .clear  (tb_if.reset_count),
    .enable (sec_wrap),
    .value  (min_value),
    .wrap   (min_wrap)
  );

  // Wrap flags already carry the hold gating, so a frozen base emits no strobes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      one_second_q  <= 1'b0;
      min_strobe_q  <= 1'b0;
      hour_strobe_q <= 1'b0;
    end else if (tb_if.reset_count) begin
      one_second_q  <= 1'b0;
      min_strobe_q  <= 1'b0;
      hour_strobe_q <= 1'b0;
    end else begin
      one_second_q  <= count_en & (pre_value == PRE_LAST);
      min_strobe_q  <= sec_wrap;
      hour_strobe_q <= min_wrap;
    end
  end

  assign tb_if.one_second = one_second_q;
  assign tb_if.one_minute = tb_if.fastwatch ? one_second_q : min_strobe_q;
  assign tb_if.one_hour   = tb_if.fastwatch ? min_strobe_q : hour_strobe_q;
  assign tb_if.sec_count  = sec_value;
  assign tb_if.min_count  = min_value;

endmodule

// File: tb/tb_timebase_gen.sv
// Bench for timebase_gen at 4/3/2 ratios: fixed vectors, corner sequences and a random run
// against an elapsed-tick reference model; hold sequences only with TIMEBASE_HOLD_EN.
module tb_timebase_gen;
  import timebase_gen_pkg::*;

  localparam int CPS   = 4;
  localparam int SPM   = 3;
  localparam int MPH   = 2;
  localparam int SEC_W = clog2_min1(SPM);
  localparam int MIN_W = clog2_min1(MPH);

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  timebase_gen_if #(.SEC_W(SEC_W), .MIN_W(MIN_W)) bus ();

  timebase_gen #(
    .CLK_PER_SEC  (CPS),
    .SEC_PER_MIN  (SPM),
    .MIN_PER_HOUR (MPH)
  ) dut (
    .clock (clock),
    .reset (reset),
    .tb_if (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: t = clock ticks counted since the last (re)start; adv = last edge counted.
  int t   = 0;
  bit adv = 1'b0;
  bit hold_v = 1'b0;

  typedef struct {
    int cyc;
    bit fw;
    bit os;
    bit om;
    bit oh;
    int sec;
    int min;
  } vec_t;

  vec_t vt[12];

  task automatic check_val(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic check_model();
    bit e_os, e_minr, e_hr, e_om, e_oh;
    int e_sec, e_min;
    e_os   = adv && (t % CPS == 0);
    e_minr = adv && (t % (CPS * SPM) == 0);
    e_hr   = adv && (t % (CPS * SPM * MPH) == 0);
    e_om   = bus.fastwatch ? e_os   : e_minr;
    e_oh   = bus.fastwatch ? e_minr : e_hr;
    e_sec  = (t / CPS) % SPM;
    e_min  = (t / (CPS * SPM)) % MPH;
    tests++;
    if (bus.one_second !== e_os || bus.one_minute !== e_om || bus.one_hour !== e_oh ||
        int'(bus.sec_count) != e_sec || int'(bus.min_count) != e_min) begin
      fails++;
      $display("FAIL model t=%0d fw=%0b: got os=%0b om=%0b oh=%0b sec=%0d min=%0d, expected os=%0b om=%0b oh=%0b sec=%0d min=%0d",
               t, bus.fastwatch, bus.one_second, bus.one_minute, bus.one_hour,
               bus.sec_count, bus.min_count, e_os, e_om, e_oh, e_sec, e_min);
    end
  endtask

  task automatic drive(input bit rc, input bit fw, input bit hd);
    bus.reset_count = rc;
    bus.fastwatch   = fw;
    hold_v          = hd;
`ifdef TIMEBASE_HOLD_EN
    bus.hold        = hd;
`endif
  endtask

  task automatic step();
    @(posedge clock);
    if (reset || bus.reset_count) begin
      t   = 0;
      adv = 1'b0;
    end else if (hold_v) begin
      adv = 1'b0;
    end else begin
      t++;
      adv = 1'b1;
    end
    #1;
    check_model();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    t   = 0;
    adv = 1'b0;
  endtask

  initial begin
    int cyc;
    bit found;
    int frozen_sec;
    bit rc, fw, hd;

    vt[0]  = '{3,  1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
    vt[1]  = '{4,  1'b0, 1'b1, 1'b0, 1'b0, 1, 0};
    vt[2]  = '{5,  1'b0, 1'b0, 1'b0, 1'b0, 1, 0};
    vt[3]  = '{8,  1'b0, 1'b1, 1'b0, 1'b0, 2, 0};
    vt[4]  = '{12, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1};
    vt[5]  = '{13, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1};
    vt[6]  = '{16, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1};
    vt[7]  = '{24, 1'b0, 1'b1, 1'b1, 1'b1, 0, 0};
    vt[8]  = '{28, 1'b1, 1'b1, 1'b1, 1'b0, 1, 0};
    vt[9]  = '{36, 1'b1, 1'b1, 1'b1, 1'b1, 0, 1};
    vt[10] = '{37, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1};
    vt[11] = '{40, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1};

    do_reset();
    check_val("reset one_second", int'(bus.one_second), 0);
    check_val("reset one_minute", int'(bus.one_minute), 0);
    check_val("reset one_hour",   int'(bus.one_hour),   0);
    check_val("reset sec_count",  int'(bus.sec_count),  0);
    check_val("reset min_count",  int'(bus.min_count),  0);

    // Fixed vectors, cycle numbers counted from reset release.
    cyc = 0;
    for (int i = 0; i < 12; i++) begin
      bus.fastwatch = vt[i].fw;
      while (cyc < vt[i].cyc) begin
        step();
        cyc++;
      end
      check_val($sformatf("vec%0d one_second", vt[i].cyc), int'(bus.one_second), int'(vt[i].os));
      check_val($sformatf("vec%0d one_minute", vt[i].cyc), int'(bus.one_minute), int'(vt[i].om));
      check_val($sformatf("vec%0d one_hour",   vt[i].cyc), int'(bus.one_hour),   int'(vt[i].oh));
      check_val($sformatf("vec%0d sec_count",  vt[i].cyc), int'(bus.sec_count),  vt[i].sec);
      check_val($sformatf("vec%0d min_count",  vt[i].cyc), int'(bus.min_count),  vt[i].min);
    end

    // reset_count on the tenth edge restarts the count; next second 4 edges later.
    do_reset();
    repeat (9) step();
    drive(1'b1, 1'b0, 1'b0);
    step();
    check_val("rc sec_count",  int'(bus.sec_count),  0);
    check_val("rc one_second", int'(bus.one_second), 0);
    drive(1'b0, 1'b0, 1'b0);
    repeat (3) step();
    check_val("rc early one_second", int'(bus.one_second), 0);
    step();
    check_val("rc one_second after 4", int'(bus.one_second), 1);
    check_val("rc sec_count after 4",  int'(bus.sec_count),  1);

    // Async reset between edges while a strobe is high clears outputs at once.
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      step();
      if (bus.one_second === 1'b1 && bus.sec_count != '0) found = 1'b1;
    end
    check_val("strobe seen before async reset", int'(found), 1);
    #2;
    reset = 1'b1;
    #1;
    check_val("async one_second", int'(bus.one_second), 0);
    check_val("async sec_count",  int'(bus.sec_count),  0);
    check_val("async min_count",  int'(bus.min_count),  0);
    step();
    reset = 1'b0;
    t   = 0;
    adv = 1'b0;
    repeat (4) step();
    check_val("post async first one_second", int'(bus.one_second), 1);

`ifdef TIMEBASE_HOLD_EN
    // Hold at prescaler=2 for 10 edges, then one_second 2 edges after release.
    do_reset();
    repeat (6) step();
    frozen_sec = int'(bus.sec_count);
    drive(1'b0, 1'b0, 1'b1);
    repeat (10) step();
    check_val("hold frozen sec_count", int'(bus.sec_count), frozen_sec);
    drive(1'b0, 1'b0, 1'b0);
    step();
    check_val("hold release +1 one_second", int'(bus.one_second), 0);
    step();
    check_val("hold release +2 one_second", int'(bus.one_second), 1);
`else
    frozen_sec = 0;
    check_val("no-hold build sec_count", int'(bus.sec_count), 1);
`endif

    // Random mode/clear/hold traffic against the tick model.
    do_reset();
    fw = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      rc = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 15) == 0) fw = ~fw;
`ifdef TIMEBASE_HOLD_EN
      hd = ($urandom_range(0, 3) == 0);
`else
      hd = 1'b0;
`endif
      drive(rc, fw, hd);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
